// File: rtl/pkt_centralized_write_pkg.sv
// Shared definitions for the packet centralized-buffer write stage:
// line-type encodings, buffer geometry, descriptor layout and FSM states.
package pkt_centralized_write_pkg;

    localparam int BUF_LINES = 8;
    localparam int BUFID_W   = 9;
    localparam int OFF_W     = 3;
    localparam int ADDR_W    = BUFID_W + OFF_W;
    localparam int DATA_W    = 134;
    localparam int CNT_W     = 16;
    localparam int LEN_W     = 8;
    localparam int DESC_W    = BUFID_W + LEN_W;

    // Line type field [133:132]
    localparam int TYPE_HI = 133;
    localparam int TYPE_LO = 132;
    localparam int INV_HI  = 131;
    localparam int INV_LO  = 128;

    localparam logic [1:0] LN_MID    = 2'b00;
    localparam logic [1:0] LN_HEAD   = 2'b01;
    localparam logic [1:0] LN_TAIL   = 2'b10;
    localparam logic [1:0] LN_SINGLE = 2'b11;

    // Descriptor layout: {bufid, byte_len}
    localparam int DESC_LEN_LO   = 0;
    localparam int DESC_BUFID_LO = LEN_W;

    // Counter slots
    localparam int CNT_NOBUF = 0;
    localparam int CNT_OVER  = 1;
    localparam int CNT_TRUNC = 2;
    localparam int NUM_CNT   = 3;

    typedef enum logic [1:0] {
        IDLE_S    = 2'd0,
        WRITE_S   = 2'd1,
        DROP_S    = 2'd2,
        DISCARD_S = 2'd3
    } wr_state_e;

    // Packet byte length: full 16-byte lines minus the tail's invalid bytes.
    // 8 lines x 16 = 128 still fits the 8-bit field.
    function automatic logic [LEN_W-1:0] calc_byte_len(input logic [3:0] lines,
                                                       input logic [3:0] inv);
        logic [8:0] total;
        total = {1'b0, lines, 4'b0000} - {5'b00000, inv};
        return total[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/pkt_centralized_write_if.sv
// Bus bundle of the write stage: packet input, buffer-ID allocate
// handshake, packet RAM write port and descriptor output.
interface pkt_centralized_write_if;
    import pkt_centralized_write_pkg::*;

    logic [DATA_W-1:0]  iv_data;
    logic               i_data_wr;
    logic               initial_finish;
    logic [BUFID_W-1:0] bufid_allocate;
    logic               bufid_allocate_wr;
    logic               bufid_allocate_ack;
    logic [DATA_W-1:0]  pkt_ram_wdata;
    logic               pkt_ram_wr;
    logic [ADDR_W-1:0]  pkt_ram_waddr;
    logic [DESC_W-1:0]  ov_descriptor;
    logic               o_descriptor_wr;

    // Upstream / buffer manager / RAM side
    modport master (
        output iv_data, i_data_wr, initial_finish, bufid_allocate, bufid_allocate_wr,
        input  bufid_allocate_ack, pkt_ram_wdata, pkt_ram_wr, pkt_ram_waddr,
               ov_descriptor, o_descriptor_wr
    );

    // Write-stage side
    modport slave (
        input  iv_data, i_data_wr, initial_finish, bufid_allocate, bufid_allocate_wr,
        output bufid_allocate_ack, pkt_ram_wdata, pkt_ram_wr, pkt_ram_waddr,
               ov_descriptor, o_descriptor_wr
    );

endinterface

// File: rtl/pkt_centralized_write_bufid_fetch.sv
// Buffer-ID fetch: accepts one offered ID from the buffer manager, holds
// it until the packet using it has produced a descriptor.
module pkt_centralized_write_bufid_fetch
    import pkt_centralized_write_pkg::*;
(
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               initial_finish,
    input  logic [BUFID_W-1:0] bufid_allocate,
    input  logic               bufid_allocate_wr,
    input  logic               release_buf,
    output logic               bufid_allocate_ack,
    output logic               buf_valid,
    output logic [BUFID_W-1:0] cur_bufid
);

    logic               ack_q, ack_d;
    logic               buf_valid_q, buf_valid_d;
    logic [BUFID_W-1:0] cur_bufid_q, cur_bufid_d;
    logic               take;

    // Accept an offer only while empty; ack_q blocks a second accept while
    // the manager still holds wr high during the ack cycle.
    always_comb begin
        take        = initial_finish && !buf_valid_q && bufid_allocate_wr && !ack_q;
        ack_d       = take;
        buf_valid_d = buf_valid_q;
        cur_bufid_d = cur_bufid_q;
        if (take) begin
            buf_valid_d = 1'b1;
            cur_bufid_d = bufid_allocate;
        end else if (release_buf) begin
            buf_valid_d = 1'b0;
        end
    end

    // Handshake and held-ID registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ack_q       <= 1'b0;
            buf_valid_q <= 1'b0;
            cur_bufid_q <= '0;
        end else begin
            ack_q       <= ack_d;
            buf_valid_q <= buf_valid_d;
            cur_bufid_q <= cur_bufid_d;
        end
    end

    assign bufid_allocate_ack = ack_q;
    assign buf_valid          = buf_valid_q;
    assign cur_bufid          = cur_bufid_q;

endmodule

// File: rtl/pkt_centralized_write.sv
// Upstream write stage of the packet centralized buffer: writes packet
// lines into the held buffer's 8-line RAM slot, emits {bufid, length}
// descriptors and keeps drop/error statistics.
module pkt_centralized_write
    import pkt_centralized_write_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 reset_n,
    pkt_centralized_write_if.slave bus,
    output logic [CNT_W-1:0]     ov_nobuf_drop_cnt,
    output logic [CNT_W-1:0]     ov_oversize_cnt,
    output logic [CNT_W-1:0]     ov_trunc_err_cnt
);

    logic               buf_valid;
    logic [BUFID_W-1:0] cur_bufid;

    wr_state_e          state_q, state_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic               ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0]  ram_waddr_q, ram_waddr_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic               desc_wr_q, desc_wr_d;
    logic [DESC_W-1:0]  desc_q, desc_d;
    logic [NUM_CNT-1:0] cnt_inc;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]         ln_type;
    logic [3:0]         ln_inv;
    logic               is_head, is_tail;
    logic               start_pkt, do_write, do_emit;
    logic [OFF_W-1:0]   wr_off, next_off;
    logic [3:0]         emit_lines;

    assign ln_type = bus.iv_data[TYPE_HI:TYPE_LO];
    assign ln_inv  = bus.iv_data[INV_HI:INV_LO];
    assign is_head = (ln_type == LN_HEAD) || (ln_type == LN_SINGLE);
    assign is_tail = (ln_type == LN_TAIL) || (ln_type == LN_SINGLE);

    pkt_centralized_write_bufid_fetch u_fetch (
        .clk_sys            (clk_sys),
        .reset_n            (reset_n),
        .initial_finish     (bus.initial_finish),
        .bufid_allocate     (bus.bufid_allocate),
        .bufid_allocate_wr  (bus.bufid_allocate_wr),
        .release_buf        (desc_wr_d),
        .bufid_allocate_ack (bus.bufid_allocate_ack),
        .buf_valid          (buf_valid),
        .cur_bufid          (cur_bufid)
    );

    // Packet FSM: classify each line, pick RAM write / descriptor / counter events
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        ram_wr_d    = 1'b0;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;
        desc_wr_d   = 1'b0;
        desc_d      = desc_q;
        cnt_inc     = '0;
        start_pkt   = 1'b0;
        do_write    = 1'b0;
        do_emit     = 1'b0;
        wr_off      = '0;
        emit_lines  = 4'd1;
        next_off    = offset_q + 3'd1;

        if (bus.i_data_wr) begin
            case (state_q)
                WRITE_S: begin
                    if (is_head) begin
                        // Restart in the same slot; earlier lines are abandoned.
                        cnt_inc[CNT_TRUNC] = 1'b1;
                        start_pkt          = 1'b1;
                    end else if (offset_q == OFF_W'(BUF_LINES - 1)) begin
                        // Slot full: keep the bufid, swallow the rest.
                        cnt_inc[CNT_OVER] = 1'b1;
                        state_d           = is_tail ? IDLE_S : DISCARD_S;
                    end else begin
                        do_write = 1'b1;
                        wr_off   = next_off;
                        offset_d = next_off;
                        if (is_tail) begin
                            do_emit    = 1'b1;
                            emit_lines = {1'b0, next_off} + 4'd1;
                            state_d    = IDLE_S;
                        end
                    end
                end
                default: begin
                    // IDLE_S, DROP_S and DISCARD_S all restart on a head.
                    if (is_head) begin
                        if (buf_valid) begin
                            start_pkt = 1'b1;
                        end else begin
                            cnt_inc[CNT_NOBUF] = 1'b1;
                            state_d            = (ln_type == LN_SINGLE) ? IDLE_S : DROP_S;
                        end
                    end else if (is_tail) begin
                        state_d = IDLE_S;
                    end
                end
            endcase
        end

        if (start_pkt) begin
            do_write = 1'b1;
            wr_off   = '0;
            offset_d = '0;
            if (ln_type == LN_SINGLE) begin
                do_emit    = 1'b1;
                emit_lines = 4'd1;
                state_d    = IDLE_S;
            end else begin
                state_d = WRITE_S;
            end
        end

        if (do_write) begin
            ram_wr_d    = 1'b1;
            ram_waddr_d = {cur_bufid, wr_off};
            ram_wdata_d = bus.iv_data;
        end

        if (do_emit) begin
            desc_wr_d = 1'b1;
            desc_d    = {cur_bufid, calc_byte_len(emit_lines, ln_inv)};
        end
    end

    // Saturating statistics counters
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // State, output and counter registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE_S;
            offset_q    <= '0;
            ram_wr_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            desc_wr_q   <= 1'b0;
            desc_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            ram_wr_q    <= ram_wr_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            desc_wr_q   <= desc_wr_d;
            desc_q      <= desc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.pkt_ram_wr      = ram_wr_q;
    assign bus.pkt_ram_waddr   = ram_waddr_q;
    assign bus.pkt_ram_wdata   = ram_wdata_q;
    assign bus.o_descriptor_wr = desc_wr_q;
    assign bus.ov_descriptor   = desc_q;
    assign ov_nobuf_drop_cnt   = cnt_q[CNT_NOBUF];
    assign ov_oversize_cnt     = cnt_q[CNT_OVER];
    assign ov_trunc_err_cnt    = cnt_q[CNT_TRUNC];

endmodule

// File: tb/tb_pkt_centralized_write.sv
// Directed table-driven bench for pkt_centralized_write.
module tb_pkt_centralized_write;

    logic        clk_sys;
    logic        reset_n;
    logic [15:0] nobuf_cnt, over_cnt, trunc_cnt;
    int          checks;
    int          failures;

    pkt_centralized_write_if bus_if ();

    pkt_centralized_write dut (
        .clk_sys           (clk_sys),
        .reset_n           (reset_n),
        .bus               (bus_if.slave),
        .ov_nobuf_drop_cnt (nobuf_cnt),
        .ov_oversize_cnt   (over_cnt),
        .ov_trunc_err_cnt  (trunc_cnt)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        dv;
        logic [1:0]  typ;
        logic [3:0]  inv;
        logic [7:0]  tag;
        logic        awr;
        logic [8:0]  aid;
        logic        e_ack;
        logic        e_wr;
        logic [11:0] e_addr;
        logic        e_dwr;
        logic [16:0] e_desc;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    function automatic vec_t mk(logic dv, logic [1:0] typ, logic [3:0] inv, logic [7:0] tag,
                                logic awr, logic [8:0] aid, logic e_ack, logic e_wr,
                                logic [11:0] e_addr, logic e_dwr, logic [16:0] e_desc);
        vec_t v;
        v.dv = dv; v.typ = typ; v.inv = inv; v.tag = tag; v.awr = awr; v.aid = aid;
        v.e_ack = e_ack; v.e_wr = e_wr; v.e_addr = e_addr; v.e_dwr = e_dwr; v.e_desc = e_desc;
        return v;
    endfunction

    function automatic logic [133:0] line(logic [1:0] typ, logic [3:0] inv, logic [7:0] tag);
        return {typ, inv, {16{tag}}};
    endfunction

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [1:0] typ, input logic [3:0] inv,
                         input logic [7:0] tag, input logic awr, input logic [8:0] aid);
        bus_if.i_data_wr         = dv;
        bus_if.iv_data           = line(typ, inv, tag);
        bus_if.bufid_allocate_wr = awr;
        bus_if.bufid_allocate    = aid;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ram_wr"}, 134'(bus_if.pkt_ram_wr), 134'(0));
        chk({tag, "_waddr"}, 134'(bus_if.pkt_ram_waddr), 134'(0));
        chk({tag, "_wdata"}, bus_if.pkt_ram_wdata, 134'(0));
        chk({tag, "_desc_wr"}, 134'(bus_if.o_descriptor_wr), 134'(0));
        chk({tag, "_desc"}, 134'(bus_if.ov_descriptor), 134'(0));
        chk({tag, "_ack"}, 134'(bus_if.bufid_allocate_ack), 134'(0));
        chk({tag, "_nobuf"}, 134'(nobuf_cnt), 134'(0));
        chk({tag, "_over"}, 134'(over_cnt), 134'(0));
        chk({tag, "_trunc"}, 134'(trunc_cnt), 134'(0));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus_if.initial_finish = 1'b0;
        drive(1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 9'd0);

        //                dv typ    inv  tag    awr aid    ack wr  addr    dwr desc
        vecs[0]  = mk(1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 9'd0, 1'b1, 1'b0, 12'd0,  1'b0, 17'd0);
        vecs[1]  = mk(1'b1, 2'b01, 4'd0, 8'h01, 1'b1, 9'd0, 1'b0, 1'b1, 12'd0,  1'b0, 17'd0);
        vecs[2]  = mk(1'b1, 2'b00, 4'd0, 8'h02, 1'b1, 9'd0, 1'b0, 1'b1, 12'd1,  1'b0, 17'd0);
        vecs[3]  = mk(1'b1, 2'b10, 4'd4, 8'h03, 1'b0, 9'd0, 1'b0, 1'b1, 12'd2,  1'b1, {9'd0, 8'd44});
        vecs[4]  = mk(1'b0, 2'b11, 4'd0, 8'hEE, 1'b1, 9'd5, 1'b1, 1'b0, 12'd0,  1'b0, 17'd0);
        vecs[5]  = mk(1'b1, 2'b11, 4'd0, 8'h04, 1'b0, 9'd0, 1'b0, 1'b1, 12'd40, 1'b1, {9'd5, 8'd16});
        vecs[6]  = mk(1'b1, 2'b01, 4'd0, 8'h05, 1'b0, 9'd0, 1'b0, 1'b0, 12'd0,  1'b0, 17'd0);
        vecs[7]  = mk(1'b1, 2'b00, 4'd0, 8'h06, 1'b0, 9'd0, 1'b0, 1'b0, 12'd0,  1'b0, 17'd0);
        vecs[8]  = mk(1'b1, 2'b10, 4'd0, 8'h07, 1'b0, 9'd0, 1'b0, 1'b0, 12'd0,  1'b0, 17'd0);
        vecs[9]  = mk(1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 9'd7, 1'b1, 1'b0, 12'd0,  1'b0, 17'd0);
        vecs[10] = mk(1'b1, 2'b01, 4'd0, 8'h10, 1'b0, 9'd0, 1'b0, 1'b1, 12'd56, 1'b0, 17'd0);
        for (int i = 0; i < 7; i++) begin
            vecs[11+i] = mk(1'b1, 2'b00, 4'd0, 8'(8'h11 + i), 1'b0, 9'd0,
                            1'b0, 1'b1, 12'(57 + i), 1'b0, 17'd0);
        end
        vecs[18] = mk(1'b1, 2'b00, 4'd0, 8'h18, 1'b0, 9'd0, 1'b0, 1'b0, 12'd0,  1'b0, 17'd0);
        vecs[19] = mk(1'b1, 2'b10, 4'd0, 8'h19, 1'b0, 9'd0, 1'b0, 1'b0, 12'd0,  1'b0, 17'd0);
        vecs[20] = mk(1'b1, 2'b01, 4'd0, 8'h20, 1'b0, 9'd0, 1'b0, 1'b1, 12'd56, 1'b0, 17'd0);
        vecs[21] = mk(1'b1, 2'b10, 4'd0, 8'h21, 1'b0, 9'd0, 1'b0, 1'b1, 12'd57, 1'b1, {9'd7, 8'd32});
        vecs[22] = mk(1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 9'd3, 1'b1, 1'b0, 12'd0,  1'b0, 17'd0);
        vecs[23] = mk(1'b1, 2'b01, 4'd0, 8'h30, 1'b0, 9'd0, 1'b0, 1'b1, 12'd24, 1'b0, 17'd0);
        vecs[24] = mk(1'b1, 2'b00, 4'd0, 8'h31, 1'b0, 9'd0, 1'b0, 1'b1, 12'd25, 1'b0, 17'd0);
        vecs[25] = mk(1'b1, 2'b01, 4'd0, 8'h32, 1'b0, 9'd0, 1'b0, 1'b1, 12'd24, 1'b0, 17'd0);
        vecs[26] = mk(1'b1, 2'b00, 4'd0, 8'h33, 1'b0, 9'd0, 1'b0, 1'b1, 12'd25, 1'b0, 17'd0);
        vecs[27] = mk(1'b1, 2'b10, 4'd0, 8'h34, 1'b0, 9'd0, 1'b0, 1'b1, 12'd26, 1'b1, {9'd3, 8'd48});
        vecs[28] = mk(1'b1, 2'b11, 4'd0, 8'h40, 1'b1, 9'd9, 1'b1, 1'b0, 12'd0,  1'b0, 17'd0);
        vecs[29] = mk(1'b1, 2'b11, 4'd15, 8'h41, 1'b0, 9'd0, 1'b0, 1'b1, 12'd72, 1'b1, {9'd9, 8'd1});

        repeat (3) @(posedge clk_sys);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        bus_if.initial_finish = 1'b1;
        @(posedge clk_sys);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].dv, vecs[i].typ, vecs[i].inv, vecs[i].tag, vecs[i].awr, vecs[i].aid);
            @(posedge clk_sys);
            #1;
            $display("vec %0d: typ=%b dv=%b awr=%b -> ack=%b wr=%b addr=%0d dwr=%b desc=%0h",
                     i, vecs[i].typ, vecs[i].dv, vecs[i].awr, bus_if.bufid_allocate_ack,
                     bus_if.pkt_ram_wr, bus_if.pkt_ram_waddr, bus_if.o_descriptor_wr,
                     bus_if.ov_descriptor);
            chk($sformatf("v%0d_ack", i), 134'(bus_if.bufid_allocate_ack), 134'(vecs[i].e_ack));
            chk($sformatf("v%0d_ram_wr", i), 134'(bus_if.pkt_ram_wr), 134'(vecs[i].e_wr));
            if (vecs[i].e_wr) begin
                chk($sformatf("v%0d_waddr", i), 134'(bus_if.pkt_ram_waddr), 134'(vecs[i].e_addr));
                chk($sformatf("v%0d_wdata", i), bus_if.pkt_ram_wdata,
                    line(vecs[i].typ, vecs[i].inv, vecs[i].tag));
            end
            chk($sformatf("v%0d_desc_wr", i), 134'(bus_if.o_descriptor_wr), 134'(vecs[i].e_dwr));
            if (vecs[i].e_dwr) begin
                chk($sformatf("v%0d_desc", i), 134'(bus_if.ov_descriptor), 134'(vecs[i].e_desc));
            end
        end
        chk("nobuf_cnt", 134'(nobuf_cnt), 134'(2));
        chk("oversize_cnt", 134'(over_cnt), 134'(1));
        chk("trunc_cnt", 134'(trunc_cnt), 134'(1));

        // Reset in the middle of a packet held in bufid 2
        drive(1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 9'd2);
        @(posedge clk_sys);
        #1;
        chk("mid_rst_ack", 134'(bus_if.bufid_allocate_ack), 134'(1));
        drive(1'b1, 2'b01, 4'd0, 8'h50, 1'b0, 9'd0);
        @(posedge clk_sys);
        #1;
        chk("mid_rst_head_wr", 134'(bus_if.pkt_ram_wr), 134'(1));
        chk("mid_rst_head_addr", 134'(bus_if.pkt_ram_waddr), 134'(16));
        drive(1'b1, 2'b00, 4'd0, 8'h51, 1'b0, 9'd0);
        #2;
        reset_n = 1'b0;
        #1;
        $display("async reset mid-packet: ram_wr=%b desc_wr=%b nobuf=%0d",
                 bus_if.pkt_ram_wr, bus_if.o_descriptor_wr, nobuf_cnt);
        check_all_zero("async_rst");
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        // The abandoned packet's middle line must be ignored after reset
        drive(1'b1, 2'b00, 4'd0, 8'h52, 1'b0, 9'd0);
        @(posedge clk_sys);
        #1;
        chk("post_rst_mid_wr", 134'(bus_if.pkt_ram_wr), 134'(0));
        // The held bufid was lost, so a new head is dropped
        drive(1'b1, 2'b01, 4'd0, 8'h53, 1'b0, 9'd0);
        @(posedge clk_sys);
        #1;
        chk("post_rst_head_wr", 134'(bus_if.pkt_ram_wr), 134'(0));
        chk("post_rst_nobuf", 134'(nobuf_cnt), 134'(1));
        drive(1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 9'd0);
        @(posedge clk_sys);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
